// File: rtl/arr_frame_pkg.sv
// Shared types and sizing helpers for the lane-serial array-frame receiver.
package arr_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } rx_state_e;

    typedef logic [0:1][3:2][1:2] row_t;

    function automatic int beats_per_row(input int row_bits, input int lane_w);
        return row_bits / lane_w;
    endfunction

    function automatic int frame_beats(input int rows, input int row_bits, input int lane_w);
        return rows * beats_per_row(row_bits, lane_w);
    endfunction

endpackage

// File: rtl/arr_row_shifter.sv
// One frame row: lanes shift in at the LSB so the first beat ends up in the MSBs.
module arr_row_shifter #(
    parameter int LANE_W   = 2,
    parameter int ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                we,
    input  logic [LANE_W-1:0]   d,
    output logic [ROW_BITS-1:0] row
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (clr) begin
            // clear and first write can coincide when a new frame starts
            row <= we ? {{(ROW_BITS-LANE_W){1'b0}}, d} : '0;
        end else if (we) begin
            row <= {row[ROW_BITS-LANE_W-1:0], d};
        end
    end

endmodule

// File: rtl/arr_frame_rx.sv
// Reassembles a 2-bit lane stream into ROWS packed rows, held until the consumer takes them.
// Optional macro ARR_FRAME_RX_XZ_CHECK_EN adds out_xz, flagging frames that carried x/z bits.
module arr_frame_rx
    import arr_frame_pkg::*;
#(
    parameter int LANE_W     = 2,
    parameter int ROW_BITS   = 8,
    parameter int ROWS       = 3,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [LANE_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_BITS-1:0]   out_frame [1:ROWS],
    output logic                  out_restart,
    output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
    ,
    output logic                  out_xz
`endif
);

    localparam int BPR   = beats_per_row(ROW_BITS, LANE_W);
    localparam int BEATS = frame_beats(ROWS, ROW_BITS, LANE_W);
    localparam int CNT_W = $clog2(BEATS);

    rx_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, wr_idx, row_sel;
    logic             acc, clr_all, wr, drop, restart_nx;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign acc       = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        clr_all    = 1'b0;
        wr         = 1'b0;
        drop       = 1'b0;
        restart_nx = 1'b0;
        case (state)
            IDLE: begin
                if (acc && in_sof) begin
                    clr_all  = 1'b1;
                    wr       = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    state_nx = COLLECT;
                end else if (acc) begin
                    drop = 1'b1;
                end
            end
            COLLECT: begin
                if (acc && in_sof) begin
                    clr_all    = 1'b1;
                    wr         = 1'b1;
                    cnt_nx     = CNT_W'(1);
                    restart_nx = 1'b1;
                end else if (acc) begin
                    wr = 1'b1;
                    if (cnt == CNT_W'(BEATS-1)) begin
                        cnt_nx   = '0;
                        state_nx = HOLD;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            out_restart <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            cnt         <= cnt_nx;
            out_restart <= restart_nx;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    // a new frame always lands in row 1 regardless of where the old one stopped
    assign wr_idx  = clr_all ? '0 : cnt;
    assign row_sel = wr_idx / CNT_W'(BPR);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        arr_row_shifter #(
            .LANE_W   (LANE_W),
            .ROW_BITS (ROW_BITS)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_all),
            .we    (wr && (row_sel == CNT_W'(r))),
            .d     (in_data),
            .row   (out_frame[r+1])
        );
    end

`ifdef ARR_FRAME_RX_XZ_CHECK_EN
    logic xz_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       xz_seen <= 1'b0;
        else if (clr_all) xz_seen <= $isunknown(in_data);
        else if (wr)      xz_seen <= xz_seen | $isunknown(in_data);
    end

    assign out_xz = (state == HOLD) && xz_seen;
`endif

endmodule

// File: tb/tb_arr_frame_rx.sv
// Randomised and directed bench for arr_frame_rx against a beat-queue reference model.
module tb_arr_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sof, out_ready;
    logic [1:0] in_data;
    logic       in_ready, out_valid, out_restart;
    logic [7:0] out_frame [1:3];
    logic [7:0] drop_cnt;
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
    logic       out_xz;
`endif

    always #5 clk = ~clk;

    arr_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_frame   (out_frame),
        .out_restart (out_restart),
        .drop_cnt    (drop_cnt)
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
        ,
        .out_xz      (out_xz)
`endif
    );

    // reference model: the frame is just the list of beats accepted so far
    logic [1:0] m_beats [$];
    bit         m_hold, m_restart, m_xz;
    int         m_drop;
    int         n_total, n_bad, n_restart;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_frame();
        logic [23:0] f;
        f = '0;
        foreach (m_beats[i]) f = {f[21:0], m_beats[i]};
        return f;
    endfunction

    function automatic logic [23:0] flat();
        return {out_frame[1], out_frame[2], out_frame[3]};
    endfunction

    task automatic model_reset();
        m_beats.delete();
        m_hold    = 1'b0;
        m_restart = 1'b0;
        m_xz      = 1'b0;
        m_drop    = 0;
    endtask

    task automatic model_update(input logic v, input logic s, input logic [1:0] d, input logic r);
        m_restart = 1'b0;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                m_beats.delete();
            end
        end else if (v) begin
            if (s) begin
                if (m_beats.size() > 0) m_restart = 1'b1;
                m_beats.delete();
                m_beats.push_back(d);
                m_xz = $isunknown(d);
            end else if (m_beats.size() == 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_beats.push_back(d);
                m_xz = m_xz | $isunknown(d);
                if (m_beats.size() == 12) m_hold = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_restart", 32'(out_restart), 32'(m_restart));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_hold) chk("frame", 32'(flat()), 32'(exp_frame()));
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
        chk("out_xz", 32'(out_xz), 32'(m_hold && m_xz));
`endif
    endtask

    task automatic step(input logic v, input logic s, input logic [1:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_update(v, s, d, r);
        #1;
        compare();
        if (out_restart === 1'b1) n_restart++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_frame", 32'(flat()), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_restart = 0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 2'b00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare();
        chk("rst_frame0", 32'(flat()), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // full frame of 2'b01
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 2'b01, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_frame", 32'(flat()), 32'h555555);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("t1_released", 32'(out_valid), 32'h0);

        // backpressure with extra beats offered while holding
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 2'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'($urandom), 2'($urandom), 1'b0);
            chk("t2_in_ready", 32'(in_ready), 32'h0);
        end
        step(1'b1, 1'b0, 2'b11, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("t2_single_release", 32'(out_valid), 32'h0);

        // mid-frame restart
        n_restart = 0;
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 2'b11, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 2'b10, 1'b0);
        chk("t3_frame", 32'(flat()), 32'hAAAAAA);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("t3_restart_once", 32'(n_restart), 32'h1);

        // IDLE drops saturate
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 2'($urandom), 1'($urandom));
        chk("t4_drop_sat", 32'(drop_cnt), 32'hFF);

        // reset mid-frame, then a clean all-zero frame
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 2'b11, 1'b0);
        n_restart = 0;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 2'b00, 1'b0);
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_frame", 32'(flat()), 32'h0);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("t5_no_restart", 32'(n_restart), 32'h0);

        // x in beat 4 propagates, then a clean frame
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, (i == 4) ? 2'bx1 : 2'b10, 1'b0);
        chk("t6_xframe", 32'(flat()), 32'({8'hAA, 8'bx110_1010, 8'hAA}));
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
        chk("t6_xz_set", 32'(out_xz), 32'h1);
`endif
        step(1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 2'b01, 1'b0);
`ifdef ARR_FRAME_RX_XZ_CHECK_EN
        chk("t6_xz_clear", 32'(out_xz), 32'h0);
`endif
        step(1'b0, 1'b0, 2'b00, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 10) == 0, 2'($urandom), ($urandom % 3) == 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/arr_frame_rx.md
Name: arr_frame_rx

Overview:
- Receive-side counterpart of the array-frame drivers: reassembles a serial stream of 2-bit lanes into an unpacked array of packed rows.
- Each row is shaped [0:1][3:2][1:2], i.e. 8 bits; a frame holds ROWS rows.
- Sits between a lane-serial link and any consumer expecting a full multi-dimensional array in one handshake.
- Valid/ready on both sides; start-of-frame marker on input.

Parameters:
- LANE_W, 2, bits per input beat (innermost dimension).
- ROW_BITS, 8, bits per row; must be a multiple of LANE_W.
- ROWS, 3, rows per frame (unpacked dimension [1:ROWS]).
- DROP_CNT_W, 8, width of the saturating dropped-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat present.
- in_ready  output  1  receiver accepts beat.
- in_sof  input  1  beat is first of a frame.
- in_data  input  LANE_W  lane payload (4-state logic).
- out_valid  output  1  frame complete and held.
- out_ready  input  1  consumer takes frame.
- out_frame  output  [1:ROWS] x ROW_BITS  reassembled frame, unpacked by row.
- out_restart  output  1  one-cycle pulse: frame aborted by mid-frame sof.
- drop_cnt  output  DROP_CNT_W  beats discarded in IDLE, saturating.

Behaviour:
- Constants:
  - BEATS_PER_ROW = ROW_BITS/LANE_W (4).
  - BEATS = ROWS*BEATS_PER_ROW (12).
  - Beat counter width is $clog2(BEATS).
- Accept condition: in_valid && in_ready.
- Reset (async, rst_n=0):
  - state=IDLE, beat counter 0, out_frame all 0.
  - out_valid=0, out_restart=0, drop_cnt=0.
  - in_ready is 1 while held in reset (combinational from state).
- in_ready = (state != HOLD).
- FSM IDLE:
  - Accepted beat with in_sof: writes beat 0, count=1, go to COLLECT.
  - Accepted beat without in_sof: discarded, drop_cnt += 1 (saturates at all-ones).
- FSM COLLECT:
  - Accepted beat without sof: written at index count, count += 1.
  - When the beat at index BEATS-1 is accepted: go to HOLD; out_valid=1 on the next cycle (1-cycle latency after last beat).
  - Accepted beat with in_sof: pulse out_restart next cycle, count=1, beat becomes beat 0 of a new frame. Unwritten bits of the new frame are cleared to 0.
- FSM HOLD:
  - out_valid=1 and out_frame stable until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle.
  - No beats accepted while in HOLD.
- Fill order:
  - Row 1 first, then row 2, and so on.
  - Within a row, MSB first: beat k of a row lands at bits [ROW_BITS-1-k*LANE_W -: LANE_W].
- Frame register is cleared to 0 on every sof acceptance before the beat is written.
- Data values propagate unaltered, including x/z.
- Reset mid-frame discards the partial frame immediately.

Optional Feature:
- Macro: ARR_FRAME_RX_XZ_CHECK_EN.
- Defined: adds output out_xz (1 bit).
  - Set in HOLD if any accepted beat of the frame had an x or z bit (checked with $isunknown).
  - Cleared on sof acceptance and on reset.
- Undefined: port absent, no 4-state checks, data path unchanged.

Decomposition:
- Package arr_frame_pkg:
  - State enum rx_state_e {IDLE, COLLECT, HOLD}.
  - Localparam functions for BEATS_PER_ROW and BEATS.
  - Row typedef logic [0:1][3:2][1:2] row_t.
- Sub-module arr_row_shifter: one row's MSB-first lane shift register with clear and write-enable.
  - Instantiated ROWS times, each enabled by row-select decode of the beat counter.

Test Plan:
- Full frame: 12 beats of in_data=2'b01, sof on beat 0, in_valid continuous.
  -> In cycle 13, out_valid=1 and every row is 8'h55.
  -> out_ready=1 then returns the FSM to IDLE, out_valid=0 the next cycle.
- Backpressure: complete frame with out_ready=0 for 5 cycles.
  -> in_ready=0 and out_frame stable throughout.
  -> Extra in_valid beats not consumed; release is a single handshake.
- Mid-frame sof: 6 beats of 2'b11, then sof plus 12 beats of 2'b10.
  -> out_restart pulses once; delivered frame rows all 8'hAA.
- IDLE drops: 300 beats with in_sof=0 in IDLE -> drop_cnt saturates at 8'hFF, no out_valid.
- Reset mid-frame: rst_n low after 7 beats, then a clean frame of 2'b00.
  -> All outputs reset asynchronously; next frame is all 8'h00 with no restart pulse.
- With ARR_FRAME_RX_XZ_CHECK_EN: beat 4 carries 2'bx1 -> out_xz=1 in HOLD; a following clean frame -> out_xz=0.
